// File: rtl/rename_pkg.sv
// Shared rename/commit definitions: ROB geometry, physical-register types and
// the commit interface entry carried on each commit lane.
package rename_pkg;

  localparam int COMMIT_WIDTH = 2;
  localparam int PREG_NUM     = 64;
  localparam int DATA_WIDTH   = 64;
  localparam int PREG_W       = $clog2(PREG_NUM);
  localparam int BANK_W       = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

  typedef logic [PREG_W-1:0] preg_addr_t;
  typedef logic [BANK_W-1:0] bank_t;

  typedef struct packed {
    preg_addr_t            dst;
    logic [DATA_WIDTH-1:0] data;
  } commit_req_t;

  // A ROB entry lives in the bank named by the low bits of its preg number.
  function automatic bank_t bank(input preg_addr_t dst);
    return (COMMIT_WIDTH == 1) ? bank_t'(0) : dst[BANK_W-1:0];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, searching upward
// modulo N. Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] k;

  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx_o   = '0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      k = ptr_i + IW'(i);
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        idx_o    = k;
        gnt_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/commit_arbiter.sv
// Buffers one writeback result per functional unit and shares the banked ROB
// commit lanes among them, one round-robin winner per lane per cycle.
module commit_arbiter
  import rename_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [N_REQ-1:0]                       req_valid,
  input  preg_addr_t [N_REQ-1:0]                 req_dst,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]       req_data,
  output logic [N_REQ-1:0]                       req_ready,
  output logic [COMMIT_WIDTH-1:0]                commit_valid,
  output preg_addr_t [COMMIT_WIDTH-1:0]          commit_dst,
  output logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0] commit_data,
  output logic                                   busy
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]                    slot_v_q, slot_v_d;
  commit_req_t                         slot_q [N_REQ];
  logic [COMMIT_WIDTH-1:0][IW-1:0]     rr_q, rr_d;

  logic [COMMIT_WIDTH-1:0][N_REQ-1:0]  lane_cand, lane_gnt;
  logic [COMMIT_WIDTH-1:0]             lane_vld;
  logic [COMMIT_WIDTH-1:0][IW-1:0]     lane_idx;
  logic [N_REQ-1:0]                    granted, accept;

  always_comb begin
    lane_cand = '0;
    for (int b = 0; b < COMMIT_WIDTH; b++)
      for (int k = 0; k < N_REQ; k++)
        lane_cand[b][k] = slot_v_q[k] && (bank(slot_q[k].dst) == bank_t'(b));
  end

  for (genvar b = 0; b < COMMIT_WIDTH; b++) begin : g_lane
    rr_pick #(.N(N_REQ)) u_pick (
      .req_i  (lane_cand[b]),
      .ptr_i  (rr_q[b]),
      .gnt_o  (lane_gnt[b]),
      .valid_o(lane_vld[b]),
      .idx_o  (lane_idx[b])
    );
  end

  always_comb begin
    granted = '0;
    for (int b = 0; b < COMMIT_WIDTH; b++) granted |= lane_gnt[b];
  end

  // Ready depends on registered state and flush only, never on req_valid.
  assign req_ready = {N_REQ{~flush}} & (~slot_v_q | granted);
  assign accept    = req_valid & req_ready;
  assign busy      = |slot_v_q;

  always_comb begin
    for (int b = 0; b < COMMIT_WIDTH; b++) begin
      commit_valid[b] = lane_vld[b] & ~flush;
      commit_dst[b]   = slot_q[lane_idx[b]].dst;
      commit_data[b]  = slot_q[lane_idx[b]].data;
      rr_d[b]         = lane_vld[b] ? lane_idx[b] + IW'(1) : rr_q[b];
    end
    for (int k = 0; k < N_REQ; k++) begin
      slot_v_d[k] = slot_v_q[k];
      if (accept[k])       slot_v_d[k] = 1'b1;
      else if (granted[k]) slot_v_d[k] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      slot_v_q <= '0;
      rr_q     <= '0;
    end else begin
      slot_v_q <= slot_v_d;
      rr_q     <= rr_d;
    end
  end

  // NOTE: slot payload is deliberately not reset; it is only observed while
  // its valid bit is set, and skipping the reset keeps it plain storage.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_REQ; k++)
      if (accept[k]) slot_q[k] <= '{dst: req_dst[k], data: req_data[k]};
  end

endmodule

// File: tb/tb_commit_arbiter.sv
// Self-checking bench for commit_arbiter: directed scenarios plus randomized
// traffic scored against a queue-free behavioural model of the slots.
module tb_commit_arbiter;
  import rename_pkg::*;

  localparam int N  = 4;
  localparam int CW = COMMIT_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                              reset = 1'b1;
  logic                              flush = 1'b0;
  logic [N-1:0]                      req_valid = '0;
  preg_addr_t [N-1:0]                req_dst = '0;
  logic [N-1:0][DATA_WIDTH-1:0]      req_data = '0;
  logic [N-1:0]                      req_ready;
  logic [CW-1:0]                     commit_valid;
  preg_addr_t [CW-1:0]               commit_dst;
  logic [CW-1:0][DATA_WIDTH-1:0]     commit_data;
  logic                              busy;

  commit_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_dst(req_dst), .req_data(req_data),
    .req_ready(req_ready), .commit_valid(commit_valid),
    .commit_dst(commit_dst), .commit_data(commit_data), .busy(busy)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: one buffered result per requester, one pointer per lane.
  bit                    m_v    [N];
  int                    m_dst  [N];
  logic [DATA_WIDTH-1:0] m_data [N];
  int                    m_rr   [CW];

  // Snapshot of the cycle most recently stepped, for directed checks.
  logic [CW-1:0]                 obs_cv;
  logic [N-1:0]                  obs_ready;
  logic                          obs_busy;
  preg_addr_t [CW-1:0]           obs_dst;
  logic [CW-1:0][DATA_WIDTH-1:0] obs_data;

  task automatic model_clear();
    for (int k = 0; k < N; k++) m_v[k] = 1'b0;
    for (int b = 0; b < CW; b++) m_rr[b] = 0;
  endtask

  // One clock cycle: score the DUT against the model, then advance both.
  task automatic cyc();
    int            win [CW];
    bit            gr  [N];
    logic [CW-1:0] e_cv;
    logic [N-1:0]  e_rdy;
    logic          e_busy;
    @(negedge clk);
    e_busy = 1'b0;
    for (int k = 0; k < N; k++) gr[k] = 1'b0;
    for (int b = 0; b < CW; b++) begin
      win[b] = -1;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr[b] + i) % N;
        if (win[b] < 0 && m_v[k] && (m_dst[k] % CW) == b) win[b] = k;
      end
      if (win[b] >= 0) gr[win[b]] = 1'b1;
      e_cv[b] = (win[b] >= 0) && !flush;
    end
    for (int k = 0; k < N; k++) begin
      e_rdy[k] = !flush && (!m_v[k] || gr[k]);
      if (m_v[k]) e_busy = 1'b1;
    end

    compared++;
    if (commit_valid !== e_cv) begin
      mismatched++;
      $display("FAIL model commit_valid t=%0t: got %b want %b", $time, commit_valid, e_cv);
    end
    compared++;
    if (req_ready !== e_rdy) begin
      mismatched++;
      $display("FAIL model req_ready t=%0t: got %b want %b", $time, req_ready, e_rdy);
    end
    compared++;
    if (busy !== e_busy) begin
      mismatched++;
      $display("FAIL model busy t=%0t: got %b want %b", $time, busy, e_busy);
    end
    for (int b = 0; b < CW; b++) begin
      if (e_cv[b]) begin
        compared++;
        if (commit_dst[b] !== preg_addr_t'(m_dst[win[b]]) ||
            commit_data[b] !== m_data[win[b]]) begin
          mismatched++;
          $display("FAIL model lane%0d t=%0t: got dst=%0d data=%h want dst=%0d data=%h",
                   b, $time, commit_dst[b], commit_data[b], m_dst[win[b]], m_data[win[b]]);
        end
      end
    end

    obs_cv = commit_valid; obs_ready = req_ready; obs_busy = busy;
    obs_dst = commit_dst;  obs_data = commit_data;

    @(posedge clk);
    if (reset || flush) begin
      model_clear();
    end else begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && e_rdy[k]) begin
          m_v[k]    = 1'b1;
          m_dst[k]  = int'(req_dst[k]);
          m_data[k] = req_data[k];
        end else if (gr[k]) begin
          m_v[k] = 1'b0;
        end
      end
      for (int b = 0; b < CW; b++)
        if (win[b] >= 0) m_rr[b] = (win[b] + 1) % N;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; flush = 1'b0; req_valid = '0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      compared++;
      if (obs_cv !== 2'b00 || obs_ready !== 4'hF || obs_busy !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_idle: got cv=%b rdy=%b busy=%b want cv=00 rdy=1111 busy=0",
                 obs_cv, obs_ready, obs_busy);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 4'b0001; req_dst[0] = 6'd5; req_data[0] = 64'hAA;
    cyc();
    req_valid = '0;
    cyc();
    compared++;
    if (obs_cv !== 2'b10 || obs_dst[1] !== 6'd5 || obs_data[1] !== 64'hAA) begin
      mismatched++;
      $display("FAIL single: got cv=%b dst1=%0d data1=%h want cv=10 dst1=5 data1=aa",
               obs_cv, obs_dst[1], obs_data[1]);
    end
    cyc();
    compared++;
    if (obs_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_drain: got busy=%b want 0", obs_busy);
    end
  endtask

  task automatic test_two_banks();
    apply_reset();
    req_valid = 4'b0011;
    req_dst[0] = 6'd2; req_data[0] = {$urandom, $urandom};
    req_dst[1] = 6'd3; req_data[1] = {$urandom, $urandom};
    cyc();
    req_valid = '0;
    cyc();
    compared++;
    if (obs_cv !== 2'b11 || obs_dst[0] !== 6'd2 || obs_dst[1] !== 6'd3 ||
        obs_ready[1:0] !== 2'b11) begin
      mismatched++;
      $display("FAIL two_banks: got cv=%b dst0=%0d dst1=%0d rdy=%b want cv=11 dst0=2 dst1=3 rdy=xx11",
               obs_cv, obs_dst[0], obs_dst[1], obs_ready);
    end
    cyc();
  endtask

  task automatic test_same_bank();
    apply_reset();
    req_valid = 4'b0011;
    req_dst[0] = 6'd2; req_data[0] = 64'h1111;
    req_dst[1] = 6'd4; req_data[1] = 64'h2222;
    cyc();
    req_valid = '0;
    cyc();
    compared++;
    if (obs_cv !== 2'b01 || obs_dst[0] !== 6'd2 || obs_ready[1] !== 1'b0) begin
      mismatched++;
      $display("FAIL same_bank_first: got cv=%b dst0=%0d rdy1=%b want cv=01 dst0=2 rdy1=0",
               obs_cv, obs_dst[0], obs_ready[1]);
    end
    cyc();
    compared++;
    if (obs_cv !== 2'b01 || obs_dst[0] !== 6'd4) begin
      mismatched++;
      $display("FAIL same_bank_second: got cv=%b dst0=%0d want cv=01 dst0=4", obs_cv, obs_dst[0]);
    end
    cyc();
  endtask

  task automatic refresh(input int k);
    req_dst[k]  = preg_addr_t'($urandom_range(0, PREG_NUM/2 - 1) * 2);
    req_data[k] = {8'(k), 24'($urandom), $urandom};
  endtask

  task automatic test_alternate();
    apply_reset();
    req_valid = 4'b0011;
    refresh(0); refresh(1);
    cyc();
    for (int k = 0; k < 2; k++) if (obs_ready[k]) refresh(k);
    for (int i = 0; i < 8; i++) begin
      cyc();
      compared++;
      if (obs_cv[0] !== 1'b1 || obs_data[0][63:56] !== 8'(i % 2) ||
          obs_ready[1:0] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        mismatched++;
        $display("FAIL alternate[%0d]: got cv0=%b owner=%0d rdy=%b want cv0=1 owner=%0d",
                 i, obs_cv[0], obs_data[0][63:56], obs_ready[1:0], i % 2);
      end
      for (int k = 0; k < 2; k++) if (obs_ready[k]) refresh(k);
    end
    req_valid = '0;
    repeat (3) cyc();
  endtask

  task automatic test_flush();
    apply_reset();
    req_valid = 4'hF;
    for (int k = 0; k < N; k++) begin
      req_dst[k] = preg_addr_t'($urandom); req_data[k] = {$urandom, $urandom};
    end
    cyc();
    req_valid = '0; flush = 1'b1;
    cyc();
    compared++;
    if (obs_cv !== 2'b00 || obs_ready !== 4'h0) begin
      mismatched++;
      $display("FAIL flush_same_cycle: got cv=%b rdy=%b want cv=00 rdy=0000", obs_cv, obs_ready);
    end
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      compared++;
      if (obs_busy !== 1'b0 || obs_cv !== 2'b00) begin
        mismatched++;
        $display("FAIL flush_after[%0d]: got busy=%b cv=%b want busy=0 cv=00", i, obs_busy, obs_cv);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      req_valid = N'($urandom);
      for (int k = 0; k < N; k++) begin
        req_dst[k] = preg_addr_t'($urandom); req_data[k] = {$urandom, $urandom};
      end
      flush = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 127) == 0);
      cyc();
    end
    reset = 1'b0; flush = 1'b0; req_valid = '0;
    repeat (N + 1) cyc();
  endtask

  initial begin
    model_clear();
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_two_banks();
    test_same_bank();
    test_alternate();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
